// File: rtl/ha_array_reducer.sv
// Sequential final-stage reducer for the HA-array approximate multiplier.
// Adds one weighted (t,b) group per cycle into a saturating accumulator.
module ha_array_reducer #(
  parameter int GROUPS = 4,
  parameter int TW     = 9,
  parameter int BW     = 7,
  parameter int OUT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [GROUPS*TW-1:0] ha_array_t,
  input  logic [GROUPS*BW-1:0] ha_array_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     product,
  output logic                 overflow
);

  localparam int ACC_W = OUT_W + 1;
  localparam int IDX_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int GW    = ((TW > BW + 2) ? TW : BW + 2) + 1;
  localparam int SW    = ACC_W + GW + 2 * GROUPS;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUPS - 1);
  localparam logic [SW-1:0]    ACC_MAX  = SW'({ACC_W{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t                 state;
  logic [GROUPS*TW-1:0]   t_reg;
  logic [GROUPS*BW-1:0]   b_reg;
  logic [ACC_W-1:0]       acc;
  logic [IDX_W-1:0]       idx;

  logic [TW-1:0]          t_sel;
  logic [BW-1:0]          b_sel;
  logic [SW-1:0]          term;
  logic [SW-1:0]          sum;
  logic [ACC_W-1:0]       acc_next;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);

  // Datapath is sized wide enough that the pre-saturation sum can never wrap.
  always_comb begin
    t_sel    = t_reg[idx*TW +: TW];
    b_sel    = b_reg[idx*BW +: BW];
    term     = (SW'(t_sel) + (SW'(b_sel) << 2)) << {idx, 1'b0};
    sum      = SW'(acc) + term;
    acc_next = (sum > ACC_MAX) ? '1 : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      t_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      product   <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            t_reg <= ha_array_t;
            b_reg <= ha_array_b;
            acc   <= '0;
            idx   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= DONE;
            out_valid <= 1'b1;
            product   <= acc_next[OUT_W] ? '1 : acc_next[OUT_W-1:0];
            overflow  <= acc_next[OUT_W];
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              t_reg <= ha_array_t;
              b_reg <= ha_array_b;
              acc   <= '0;
              idx   <= '0;
              state <= ACC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_array_reducer.sv
// Scoreboard bench for ha_array_reducer: directed corner cases plus
// randomized transactions against an arithmetic reference model.
module tb_ha_array_reducer;

  localparam int GROUPS = 4;
  localparam int TW     = 9;
  localparam int BW     = 7;
  localparam int OUT_W  = 16;
  localparam int TBW    = GROUPS * TW;
  localparam int BBW    = GROUPS * BW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             overflow;
  logic [OUT_W-1:0] product;
  logic [TBW-1:0]   ha_array_t = '0;
  logic [BBW-1:0]   ha_array_b = '0;

  ha_array_reducer #(
    .GROUPS(GROUPS),
    .TW    (TW),
    .BW    (BW),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ha_array_t(ha_array_t),
    .ha_array_b(ha_array_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OUT_W-1:0] p;
    logic             o;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain weighted sum of every t/b bit, then clamp.
  function automatic exp_t expect_of(input logic [TBW-1:0] t, input logic [BBW-1:0] b,
                                     input int ac);
    exp_t               e;
    longint unsigned    s;
    logic [TW-1:0]      tg;
    logic [BW-1:0]      bg;
    longint unsigned    lim;
    s   = 0;
    lim = (64'd1 << OUT_W) - 1;
    for (int g = 0; g < GROUPS; g++) begin
      tg = t[g*TW +: TW];
      bg = b[g*BW +: BW];
      s += (longint'(tg) + 4 * longint'(bg)) * (longint'(1) << (2 * g));
    end
    e.o       = (s > lim);
    e.p       = e.o ? '1 : s[OUT_W-1:0];
    e.acc_cyc = ac;
    return e;
  endfunction

  // Monitor
  bit               first = 1'b1;
  bit               hold  = 1'b0;
  logic [OUT_W-1:0] held_p;
  logic             held_o;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      first = 1'b1;
      hold  = 1'b0;
    end else begin
      if (hold) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_product", product, held_p);
        check("hold_overflow", overflow, held_o);
      end
      hold = 1'b0;
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          if (first) begin
            check("latency", cyc - sb[0].acc_cyc, GROUPS);
            first = 1'b0;
          end
          if (out_ready) begin
            e = sb.pop_front();
            check("product", product, e.p);
            check("overflow", overflow, e.o);
            first = 1'b1;
          end else begin
            hold   = 1'b1;
            held_p = product;
            held_o = overflow;
          end
        end
      end
    end
  end

  task automatic scramble();
    ha_array_t = TBW'({$urandom, $urandom});
    ha_array_b = BBW'($urandom);
  endtask

  task automatic send(input logic [TBW-1:0] t, input logic [BBW-1:0] b, input bit track);
    int waited;
    bit ok;
    waited = 0;
    ok     = 1'b0;
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    ha_array_t = t;
    ha_array_b = b;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      else waited++;
    end
    if (!ok) check("accept_timeout", in_ready, 1);
    else if (track) sb.push_back(expect_of(t, b, cyc + 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  bit rnd_on = 1'b0;

  initial begin
    logic [TBW-1:0] t;
    logic [BBW-1:0] b;
    exp_t           ea;
    int             n;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_product", product, 0);
    check("reset_overflow", overflow, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Directed corners
    send('0, '0, 1'b1);
    t = '0; t[0 +: TW] = 9'h001;
    send(t, '0, 1'b1);
    t = '0; t[TW +: TW] = 9'h001;
    send(t, '0, 1'b1);
    t = '0; t[3*TW +: TW] = 9'h1FF;
    b = '0; b[3*BW +: BW] = 7'h7F;
    send(t, b, 1'b1);
    send('1, '1, 1'b1);
    wait_drain();

    // Backpressure with competing input
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    t = TBW'({$urandom, $urandom});
    b = BBW'($urandom);
    ea = expect_of(t, b, 0);
    send(t, b, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      scramble();
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_product", product, ea.p);
    end
    @(posedge clk);
    #1;
    t = TBW'({$urandom, $urandom});
    b = BBW'($urandom);
    ha_array_t = t;
    ha_array_b = b;
    out_ready  = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    sb.push_back(expect_of(t, b, cyc + 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
    wait_drain();

    // Reset during ACC aborts the transaction
    t = '0; t[0 +: TW] = 9'h005;
    send(t, '0, 1'b1);
    wait_drain();
    send('1, '1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_product", product, 0);
    check("abort_overflow", overflow, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (8) begin
      @(negedge clk);
      check("abort_no_output", out_valid, 0);
    end
    t = '0; t[2*TW +: TW] = 9'h0AB;
    b = '0; b[BW +: BW] = 7'h33;
    send(t, b, 1'b1);
    wait_drain();

    // Randomized phase with random consumer backpressure
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if ($urandom_range(0, 3) == 0) begin
        t = '1;
        b = BBW'($urandom);
      end else begin
        t = TBW'({$urandom, $urandom});
        b = BBW'($urandom);
      end
      send(t, b, 1'b1);
    end
    rnd_on = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
